key_mmio_dev: RTL
=================

# key_mmio_dev

Memory-mapped responder for the four DE0-CV push-buttons. It answers CPU loads and stores issued from the MEM stage at the key-device addresses. It synchronizes and debounces the raw active-low KEY pins and presents pressed=1 data, a sticky change-ready flag, an overrun flag and an interrupt request. The CPU's combinational D-MEM read mux selects `rdata` whenever `hit` is high.

## Interface
- `DBITS`, 32: bus data and address width.
- `KEYBITS`, 4: number of keys.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a change (10 ms at 50 MHz). Benches override it to 4.
- `ADDRKDATA`, 32'hFFFFF080: key data register address.
- `ADDRKCTRL`, 32'hFFFFF084: key control/status register address.

Ports:
- `clk`  in  1  system clock (PLL output).
- `reset`  in  1  asynchronous, active-high.
- `KEY`  in  KEYBITS  raw pins, active-low, asynchronous to clk.
- `addr`  in  DBITS  MEM-stage memory address.
- `wdata`  in  DBITS  store data.
- `we`  in  1  store strobe, one cycle per store.
- `re`  in  1  load strobe, one cycle per load.
- `rdata`  out  DBITS  read data, combinational from `addr`.
- `hit`  out  1  `addr` equals ADDRKDATA or ADDRKCTRL.
- `irq`  out  1  ready & IE, registered-state derived.

## Operation
- Input path: `KEY` is inverted, then passed through a 2-flop synchronizer (`s1`, `s2`), then into the debouncer producing `deb[KEYBITS-1:0]`.
- Debouncer (one counter for the whole vector):
  - It holds `cand` and `cnt`.
  - `deb` takes `s2` at the edge where `s2` has presented the same value, different from `deb`, on DEBOUNCE_CYCLES consecutive edges.
  - Any change of `s2` before then restarts the count with the new candidate.
  - If `s2` returns to `deb`, `cnt` clears and no update occurs.
  - `cnt` width is clog2(DEBOUNCE_CYCLES)+1; it never wraps.
- Change event `ev`: a one-cycle pulse on the edge where `deb` updates.
- KDATA (read-only): `rdata` = {zeros, `deb`}. Stores to KDATA are ignored.
- KCTRL bit layout:
  - bit0 READY (RO): sticky, set by `ev`.
  - bit2 OVERRUN (R/W0C): set when `ev` occurs while READY=1 and READY is not being cleared on that edge.
  - bit8 IE (RW).
  - All other bits read 0.
- Writes to KCTRL:
  - IE <= `wdata[8]`.
  - OVERRUN clears if `wdata[2]`=0; writing 1 leaves it unchanged.
  - `wdata[0]` is ignored.
- Read side effect: an edge with `re` & `addr`==ADDRKDATA clears READY. The read returns the pre-edge `deb`.
- Simultaneous events:
  - READY clear and `ev` on the same edge: set wins, READY stays 1, OVERRUN unchanged.
  - `we` and `re` both high: both act independently.
- Non-hit address: `rdata`=0, `hit`=0. `re`/`we` have no effect.
- Full 32-bit address compare; no aliasing.

## Timing
- Reset values: `s1`, `s2`, `cand`, `deb` = 0 (no key pressed); `cnt`=0; READY, OVERRUN, IE = 0; `irq`=0.
- `rdata`/`hit`: zero-latency combinational, valid in the same cycle `addr` is driven.
- Press latency: a raw change stable before edge N updates `deb` at edge N+1+DEBOUNCE_CYCLES. With D=4, a change before edge 1 appears at edge 6. READY and `irq` (if IE=1) rise after that same edge.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES clock cycles after synchronization never changes `deb`.
- Register writes and read-clears take effect at the edge where the strobe is sampled; the next cycle's `rdata` reflects them.
- Reset asserted mid-count: all state clears immediately. A key still held when reset deasserts is reported as a new press D+2 edges later.

## Structure
- Shared package `io_pkg` holds:
  - ADDRKDATA, ADDRKCTRL (alongside the existing HEX/LEDR/SW addresses);
  - KCTRL bit positions READY=0, OVR=2, IE=8;
  - KEYBITS.
- Sub-module `key_debounce` (params WIDTH, CYCLES; ports clk, reset, din, dout, ev) contains the synchronizer, `cand`/`cnt` logic and the `ev` pulse. The top contains address decode, the KCTRL flags and the read mux.

## Test plan
- Reset with KEY=4'hF, then addr=ADDRKDATA → `rdata`=0, `hit`=1. addr=ADDRKCTRL → `rdata`=0, `irq`=0.
- D=4: set KEY=4'hE before edge 1 and hold → `deb`=4'h1 at edge 6, READY=1. Then KDATA load → returns 1, READY=0 next cycle.
- Glitch: KEY[1] low for 3 cycles, then high → `deb` stays 0, READY stays 0, `cnt` back to 0.
- Overrun: press KEY0 (READY=1), release without a read → on the release `ev`, OVERRUN=1 and KCTRL reads 32'h5. Store KCTRL with `wdata`=0 → reads 32'h1.
- Simultaneous: a KDATA load on the exact `ev` edge of a new press → READY stays 1, OVERRUN stays 0. Store IE=1 (`wdata`=32'h100) → `irq`=1 next cycle.
- Reset pulse mid-debounce (cnt=2) with KEY0 held → all flags 0. `deb`=1 exactly 6 edges after reset deasserts. Address 32'hFFFFF088 → `hit`=0, `rdata`=0.

Source files
------------

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the memory-mapped I/O devices on the DE0-CV system.
// Holds the device address map, the key control/status bit positions, the
// number of keys and a helper that assembles the key control/status word.
// -----------------------------------------------------------------------------
package io_pkg;

  localparam int DBITS   = 32;
  localparam int KEYBITS = 4;

  // Device address map
  localparam logic [31:0] ADDRHEX   = 32'hFFFFF000;
  localparam logic [31:0] ADDRLEDR  = 32'hFFFFF020;
  localparam logic [31:0] ADDRSW    = 32'hFFFFF040;
  localparam logic [31:0] ADDRKDATA = 32'hFFFFF080;
  localparam logic [31:0] ADDRKCTRL = 32'hFFFFF084;

  // Key control/status register bit positions
  localparam int KCTRL_READY = 0;
  localparam int KCTRL_OVR   = 2;
  localparam int KCTRL_IE    = 8;

  // Assemble the key control/status word; unlisted bits read as zero.
  function automatic logic [31:0] kctrl_pack(input logic ready,
                                             input logic ovr,
                                             input logic ie);
    logic [31:0] w_word;
    w_word              = 32'h0000_0000;
    w_word[KCTRL_READY] = ready;
    w_word[KCTRL_OVR]   = ovr;
    w_word[KCTRL_IE]    = ie;
    return w_word;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer followed by a whole-vector debouncer. A new value on
// the synchronized input is accepted only after it has been presented,
// unchanged and different from the accepted value, on CYCLES consecutive
// clock edges. One shared counter serves the whole vector.
//
// Ports:
//   clk    in   1      clock
//   reset  in   1      asynchronous, active-high
//   din    in   WIDTH  asynchronous input (already active-high)
//   dout   out  WIDTH  debounced value
//   ev     out  1      high in the cycle whose closing edge updates dout
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             ev
);

  localparam int             CW      = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(CYCLES);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_deb;
  logic [CW-1:0]    r_cnt;

  logic             w_at_deb;
  logic             w_same_cand;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_upd;

  // Stability bookkeeping: count this edge as sample 1 of a new candidate or
  // as one more sample of the running candidate. Because the accept happens
  // exactly when the count reaches CYCLES, the counter never wraps.
  always_comb begin
    w_at_deb    = 1'b0;
    w_same_cand = 1'b0;
    w_cnt_inc   = {CW{1'b0}};
    w_upd       = 1'b0;
    w_at_deb    = (r_s2 == r_deb);
    w_same_cand = (r_s2 == r_cand);
    if (w_same_cand) begin
      w_cnt_inc = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_inc = {{(CW-1){1'b0}}, 1'b1};
    end
    if (!w_at_deb && (w_cnt_inc >= CNT_MAX)) begin
      w_upd = 1'b1;
    end else begin
      w_upd = 1'b0;
    end
  end

  // Synchronizer, candidate tracking and debounced-value register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= {WIDTH{1'b0}};
      r_s2   <= {WIDTH{1'b0}};
      r_cand <= {WIDTH{1'b0}};
      r_deb  <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      if (w_at_deb) begin
        // Input is back at the accepted value: abandon any pending change.
        r_cand <= r_deb;
        r_cnt  <= {CW{1'b0}};
      end else if (w_upd) begin
        r_deb  <= r_s2;
        r_cand <= r_s2;
        r_cnt  <= {CW{1'b0}};
      end else begin
        r_cand <= r_s2;
        r_cnt  <= w_cnt_inc;
      end
    end
  end

  assign dout = r_deb;
  assign ev   = w_upd;

endmodule

// File: rtl/key_mmio_dev.sv
// -----------------------------------------------------------------------------
// key_mmio_dev
// Memory-mapped responder for the DE0-CV push-buttons. Presents debounced,
// pressed=1 key data at ADDRKDATA and a control/status register at ADDRKCTRL
// (READY bit0 sticky, OVERRUN bit2 write-0-to-clear, IE bit8 read/write).
// A load of ADDRKDATA clears READY; a new debounced change sets it and wins
// over a simultaneous clear.
//
// Ports:
//   clk    in   1        system clock
//   reset  in   1        asynchronous, active-high
//   KEY    in   KEYBITS  raw active-low key pins
//   addr   in   DBITS    MEM-stage address
//   wdata  in   DBITS    store data
//   we     in   1        store strobe
//   re     in   1        load strobe
//   rdata  out  DBITS    combinational read data
//   hit    out  1        addr selects this device
//   irq    out  1        READY & IE
// -----------------------------------------------------------------------------
module key_mmio_dev #(
  parameter int               DBITS           = io_pkg::DBITS,
  parameter int               KEYBITS         = io_pkg::KEYBITS,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [DBITS-1:0] ADDRKDATA       = io_pkg::ADDRKDATA,
  parameter logic [DBITS-1:0] ADDRKCTRL       = io_pkg::ADDRKCTRL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEYBITS-1:0] KEY,
  input  logic [DBITS-1:0]   addr,
  input  logic [DBITS-1:0]   wdata,
  input  logic               we,
  input  logic               re,
  output logic [DBITS-1:0]   rdata,
  output logic               hit,
  output logic               irq
);

  import io_pkg::*;

  logic [KEYBITS-1:0] w_key_pressed;
  logic [KEYBITS-1:0] w_deb;
  logic               w_ev;
  logic               w_sel_data;
  logic               w_sel_ctrl;
  logic               w_rd_clr;
  logic               w_wr_ctrl;
  logic               w_ovr_set;
  logic [DBITS-1:0]   w_kctrl;
  logic               w_unused;

  logic               r_ready;
  logic               r_ovr;
  logic               r_ie;

  // Pins are active-low; everything downstream uses pressed=1.
  assign w_key_pressed = ~KEY;

  key_debounce #(
    .WIDTH  (KEYBITS),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (w_key_pressed),
    .dout  (w_deb),
    .ev    (w_ev)
  );

  // Address decode, strobe qualification and the combinational read mux.
  always_comb begin
    w_sel_data = 1'b0;
    w_sel_ctrl = 1'b0;
    w_rd_clr   = 1'b0;
    w_wr_ctrl  = 1'b0;
    w_ovr_set  = 1'b0;
    w_kctrl    = {DBITS{1'b0}};
    rdata      = {DBITS{1'b0}};
    w_sel_data = (addr == ADDRKDATA);
    w_sel_ctrl = (addr == ADDRKCTRL);
    w_rd_clr   = re & w_sel_data;
    w_wr_ctrl  = we & w_sel_ctrl;
    // A change arriving while READY is still unread is an overrun, unless the
    // pending value is being read on this very edge.
    w_ovr_set  = w_ev & r_ready & ~w_rd_clr;
    w_kctrl    = DBITS'(kctrl_pack(r_ready, r_ovr, r_ie));
    if (w_sel_data) begin
      rdata = {{(DBITS-KEYBITS){1'b0}}, w_deb};
    end else if (w_sel_ctrl) begin
      rdata = w_kctrl;
    end else begin
      rdata = {DBITS{1'b0}};
    end
  end

  // Control/status flags: READY set beats read-clear; OVERRUN set beats a
  // write-0 clear so an overrun is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
      r_ie    <= 1'b0;
    end else begin
      if (w_ev) begin
        r_ready <= 1'b1;
      end else if (w_rd_clr) begin
        r_ready <= 1'b0;
      end else begin
        r_ready <= r_ready;
      end

      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (w_wr_ctrl && !wdata[KCTRL_OVR]) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= r_ovr;
      end

      if (w_wr_ctrl) begin
        r_ie <= wdata[KCTRL_IE];
      end else begin
        r_ie <= r_ie;
      end
    end
  end

  assign hit      = w_sel_data | w_sel_ctrl;
  assign irq      = r_ready & r_ie;
  assign w_unused = &{1'b0, wdata};

endmodule
